// File: rtl/pcseq_pkg.sv
// Shared types and constants for the 8080 PC fetch/branch sequencer.
// Optional timeout support elsewhere is enabled by PCSEQ_TIMEOUT_EN.
package pcseq_pkg;

  localparam int PCSEQ_CMD_W   = 3;
  localparam int RST_VEC_SHIFT = 3;

  typedef enum logic [PCSEQ_CMD_W-1:0] {
    CMD_NOP         = 3'd0,
    CMD_FETCH_OP    = 3'd1,
    CMD_FETCH_IMM8  = 3'd2,
    CMD_FETCH_IMM16 = 3'd3,
    CMD_JUMP        = 3'd4,
    CMD_RST_VEC     = 3'd5
  } pcseq_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_BUMP,
    S_SETTLE,
    S_LOAD,
    S_DONE
  } pcseq_state_e;

  // RST n jumps to n*8 in page zero.
  function automatic logic [15:0] rst_vec_addr(input logic [2:0] vec);
    rst_vec_addr = 16'(vec) << RST_VEC_SHIFT;
  endfunction

endpackage

// File: rtl/pcseq_timeout.sv
// READ-phase watchdog: reloads while not waiting, counts down each stalled
// cycle, expires on the cycle that exhausts CYCLES. Used under PCSEQ_TIMEOUT_EN.
module pcseq_timeout #(
  parameter int unsigned CYCLES = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = tick_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/branch sequencer driving the 8080 PC inc/load controls and byte reads.
// Define PCSEQ_TIMEOUT_EN to abort READ after TIMEOUT_CYCLES without ack.
module pc_sequencer
  import pcseq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk50M_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_i,
  input  logic [2:0]  vec_i,
  input  logic [15:0] pc_i,
  output logic        pc_inc_o,
  output logic        pc_load_o,
  output logic [15:0] pc_addr_o,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [7:0]  opcode_o,
  output logic [15:0] operand_o,
  output logic        done_o,
  output logic        err_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  pcseq_state_e state_q, state_d;
  pcseq_cmd_e   cmd_q, cmd_d;
  logic [1:0]   bytes_q, bytes_d;
  logic [15:0]  target_q, target_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [15:0]  operand_q, operand_d;
  logic         err_q, err_d;
  logic         tmo_expire;

`ifdef PCSEQ_TIMEOUT_EN
  logic tmo_load, tmo_tick;

  assign tmo_tick = (state_q == S_READ);
  assign tmo_load = !tmo_tick || mem_ack_i;

  pcseq_timeout #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk50M_i),
    .rst_i   (rst_i),
    .load_i  (tmo_load),
    .tick_i  (tmo_tick),
    .expire_o(tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    bytes_d   = bytes_q;
    target_d  = target_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          cmd_d   = pcseq_cmd_e'(cmd_i);
          bytes_d = 2'd0;
          case (pcseq_cmd_e'(cmd_i))
            CMD_FETCH_OP, CMD_FETCH_IMM8: begin
              bytes_d = 2'd1;
              state_d = S_READ;
            end
            CMD_FETCH_IMM16: begin
              bytes_d = 2'd2;
              state_d = S_READ;
            end
            CMD_JUMP: begin
              target_d = operand_q;
              state_d  = S_LOAD;
            end
            CMD_RST_VEC: begin
              target_d = rst_vec_addr(vec_i);
              state_d  = S_LOAD;
            end
            default: state_d = S_DONE;
          endcase
        end
      end

      S_READ: begin
        if (mem_ack_i) begin
          case (cmd_q)
            CMD_FETCH_OP:   opcode_d = mem_data_i;
            CMD_FETCH_IMM8: operand_d = {8'h00, mem_data_i};
            CMD_FETCH_IMM16: begin
              // Little-endian: low byte arrives while two bytes remain.
              if (bytes_q == 2'd2) begin
                operand_d[7:0] = mem_data_i;
              end else begin
                operand_d[15:8] = mem_data_i;
              end
            end
            default: ;
          endcase
          bytes_d = bytes_q - 2'd1;
          state_d = S_BUMP;
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_BUMP:   state_d = S_SETTLE;
      S_LOAD:   state_d = S_SETTLE;
      S_SETTLE: state_d = (bytes_q != 2'd0) ? S_READ : S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50M_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cmd_q     <= CMD_NOP;
      bytes_q   <= 2'd0;
      target_q  <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      bytes_q   <= bytes_d;
      target_q  <= target_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      err_q     <= err_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign mem_req_o   = (state_q == S_READ);
  assign mem_addr_o  = mem_req_o ? pc_i : 16'h0000;
  assign pc_inc_o    = (state_q == S_BUMP);
  assign pc_load_o   = (state_q == S_LOAD);
  assign pc_addr_o   = pc_load_o ? target_q : 16'h0000;
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
  assign opcode_o    = opcode_q;
  assign operand_o   = operand_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// commands against a cycle-arithmetic reference model. Honors PCSEQ_TIMEOUT_EN.
module tb_pc_sequencer;

  logic        clk50M_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [2:0]  cmd_i;
  logic [2:0]  vec_i;
  logic [15:0] pc_i;
  logic        pc_inc_o;
  logic        pc_load_o;
  logic [15:0] pc_addr_o;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic [7:0]  opcode_o;
  logic [15:0] operand_o;
  logic        done_o;
  logic        err_o;

  always #5 clk50M_i = ~clk50M_i;

  pc_sequencer dut (
    .clk50M_i   (clk50M_i),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_i      (cmd_i),
    .vec_i      (vec_i),
    .pc_i       (pc_i),
    .pc_inc_o   (pc_inc_o),
    .pc_load_o  (pc_load_o),
    .pc_addr_o  (pc_addr_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i),
    .opcode_o   (opcode_o),
    .operand_o  (operand_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem_ovr [logic [15:0]];
  logic [7:0]  m_opcode;
  logic [15:0] m_operand;

  // Observations of one command, cycle numbers relative to the accept cycle.
  int          obs_inc[$];
  int          obs_load[$];
  logic [15:0] obs_rd[$];
  logic [15:0] obs_load_addr;
  int          obs_done, obs_err, obs_req_cnt, obs_done_cnt;
  logic        obs_ready_acc, obs_ready_after, obs_pulse_after;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Plays decoder, memory and program counter for one command.
  task automatic exec(input logic [2:0] c, input logic [2:0] v, input int d0,
                      input int d1, input bit hold, input int budget);
    int waited;
    int nreads;
    bit fin;
    obs_inc.delete(); obs_load.delete(); obs_rd.delete();
    obs_load_addr = '0; obs_done = -1; obs_err = -1; obs_req_cnt = 0;
    obs_done_cnt = 0; obs_ready_after = 1'b0; obs_pulse_after = 1'b1;
    waited = 0; nreads = 0; fin = 1'b0;
    @(negedge clk50M_i);
    obs_ready_acc = cmd_ready_o;
    cmd_valid_i = 1'b1; cmd_i = c; vec_i = v;
    for (int k = 1; k <= budget && !fin; k++) begin
      @(negedge clk50M_i);
      if (!hold) cmd_valid_i = 1'b0;
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        obs_req_cnt++;
        if (waited == 0) obs_rd.push_back(mem_addr_o);
        if (waited == ((nreads == 0) ? d0 : d1)) begin
          mem_ack_i = 1'b1; mem_data_i = mem_byte(mem_addr_o);
          waited = 0; nreads++;
        end else begin
          waited++;
        end
      end
      if (pc_inc_o) begin obs_inc.push_back(k); pc_i = pc_i + 16'd1; end
      if (pc_load_o) begin
        obs_load.push_back(k); obs_load_addr = pc_addr_o; pc_i = pc_addr_o;
      end
      if (err_o && obs_err < 0) obs_err = k;
      if (done_o) begin obs_done_cnt++; if (obs_done < 0) obs_done = k; end
      if (done_o || err_o) begin
        cmd_valid_i = 1'b0;
        @(negedge clk50M_i);
        obs_ready_after = cmd_ready_o;
        obs_pulse_after = done_o | err_o | pc_inc_o | pc_load_o;
        fin = 1'b1;
      end
    end
    cmd_valid_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; pc_i = 16'h1234;
    repeat (3) @(negedge clk50M_i);
    checks++; if ({pc_inc_o, pc_load_o, mem_req_o, done_o, err_o} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b required 00000", {pc_inc_o, pc_load_o, mem_req_o, done_o, err_o}); end
    checks++; if ({mem_addr_o, pc_addr_o} !== 32'h0) begin
      errors++; $display("FAIL reset_addrs: got %h required 0", {mem_addr_o, pc_addr_o}); end
    checks++; if ({opcode_o, operand_o} !== 24'h0) begin
      errors++; $display("FAIL reset_regs: got %h required 0", {opcode_o, operand_o}); end
    checks++; if (cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", cmd_ready_o); end
    rst_i = 1'b0;
    @(negedge clk50M_i);
    checks++; if (cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready: got %b required 1", cmd_ready_o); end
  endtask

  task automatic test_fetch_op_late_ack;
    pc_i = 16'h0100;
    exec(3'd1, 3'd0, 2, 0, 1'b0, 40);
    m_opcode = 8'hC3;
    checks++; if ((obs_rd.size() > 0 ? obs_rd[0] : 16'hDEAD) !== 16'h0100) begin
      errors++; $display("FAIL fetch_op_addr: got %h required 0100", obs_rd.size() > 0 ? obs_rd[0] : 16'hDEAD); end
    checks++; if (opcode_o !== 8'hC3) begin
      errors++; $display("FAIL fetch_op_opcode: got %h required c3", opcode_o); end
    checks++; if (obs_inc.size() !== 1 || obs_inc[0] !== 4) begin
      errors++; $display("FAIL fetch_op_inc: count %0d required 1 at cycle 4", obs_inc.size()); end
    checks++; if (obs_done !== 6) begin
      errors++; $display("FAIL fetch_op_done: got cycle %0d required 6", obs_done); end
    checks++; if (obs_ready_after !== 1'b1 || obs_pulse_after !== 1'b0) begin
      errors++; $display("FAIL fetch_op_after: ready %b pulse %b required 1 0", obs_ready_after, obs_pulse_after); end
  endtask

  task automatic test_reset_mid_read;
    pc_i = 16'h1234;
    @(negedge clk50M_i); cmd_valid_i = 1'b1; cmd_i = 3'd1;
    @(negedge clk50M_i); cmd_valid_i = 1'b0;
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 16'h1234}) begin
      errors++; $display("FAIL midread_req: got %b/%h required 1/1234", mem_req_o, mem_addr_o); end
    rst_i = 1'b1; #1;
    checks++; if ({pc_inc_o, pc_load_o, mem_req_o, done_o, err_o, mem_addr_o, pc_addr_o} !== 37'h0) begin
      errors++; $display("FAIL midread_reset_outs: got %h required 0", {pc_inc_o, pc_load_o, mem_req_o, done_o, err_o, mem_addr_o, pc_addr_o}); end
    checks++; if ({opcode_o, operand_o, cmd_ready_o} !== 25'h1) begin
      errors++; $display("FAIL midread_reset_regs: got %h required 1", {opcode_o, operand_o, cmd_ready_o}); end
    @(negedge clk50M_i); rst_i = 1'b0;
    @(negedge clk50M_i);
    checks++; if ({pc_inc_o, mem_req_o, cmd_ready_o} !== 3'b001) begin
      errors++; $display("FAIL midread_release: got %b required 001", {pc_inc_o, mem_req_o, cmd_ready_o}); end
    m_opcode = 8'h00; m_operand = 16'h0000;
  endtask

  task automatic test_imm16_then_jump;
    pc_i = 16'h0200;
    exec(3'd3, 3'd0, 0, 0, 1'b0, 40);
    checks++; if (obs_rd.size() !== 2 || obs_rd[0] !== 16'h0200 || obs_rd[1] !== 16'h0201) begin
      errors++; $display("FAIL imm16_addrs: count %0d required 2 at 0200/0201", obs_rd.size()); end
    checks++; if (operand_o !== 16'h1234) begin
      errors++; $display("FAIL imm16_operand: got %h required 1234", operand_o); end
    checks++; if (obs_inc.size() !== 2 || obs_inc[0] !== 2 || obs_inc[1] !== 5) begin
      errors++; $display("FAIL imm16_incs: count %0d required 2 at cycles 2,5", obs_inc.size()); end
    checks++; if (obs_done !== 7) begin
      errors++; $display("FAIL imm16_done: got cycle %0d required 7", obs_done); end
    m_operand = 16'h1234;
    exec(3'd4, 3'd0, 0, 0, 1'b0, 40);
    checks++; if (obs_load.size() !== 1 || obs_load[0] !== 1 || obs_load_addr !== 16'h1234) begin
      errors++; $display("FAIL jump_load: count %0d addr %h required 1 at cycle 1 addr 1234", obs_load.size(), obs_load_addr); end
    checks++; if (obs_done !== 3 || pc_i !== 16'h1234) begin
      errors++; $display("FAIL jump_done: cycle %0d pc %h required 3 1234", obs_done, pc_i); end
  endtask

  task automatic test_rst_vec_hold;
    exec(3'd5, 3'd7, 0, 0, 1'b1, 40);
    checks++; if (obs_load.size() !== 1 || obs_load[0] !== 1 || obs_load_addr !== 16'h0038) begin
      errors++; $display("FAIL rstvec_load: count %0d addr %h required 1 at cycle 1 addr 0038", obs_load.size(), obs_load_addr); end
    checks++; if (obs_done !== 3 || obs_done_cnt !== 1) begin
      errors++; $display("FAIL rstvec_done: cycle %0d count %0d required 3 1", obs_done, obs_done_cnt); end
    checks++; if (obs_ready_acc !== 1'b1 || obs_ready_after !== 1'b1 || obs_pulse_after !== 1'b0) begin
      errors++; $display("FAIL rstvec_handshake: acc %b after %b pulse %b required 1 1 0", obs_ready_acc, obs_ready_after, obs_pulse_after); end
  endtask

  task automatic test_imm8_wrap;
    pc_i = 16'hFFFF;
    exec(3'd2, 3'd0, 1, 0, 1'b0, 40);
    m_operand = 16'h00AA;
    checks++; if ((obs_rd.size() > 0 ? obs_rd[0] : 16'hDEAD) !== 16'hFFFF) begin
      errors++; $display("FAIL imm8_addr: got %h required ffff", obs_rd.size() > 0 ? obs_rd[0] : 16'hDEAD); end
    checks++; if (operand_o !== 16'h00AA) begin
      errors++; $display("FAIL imm8_operand: got %h required 00aa", operand_o); end
    checks++; if (obs_inc.size() !== 1 || pc_i !== 16'h0000 || obs_done !== 5) begin
      errors++; $display("FAIL imm8_inc: count %0d pc %h done %0d required 1 0000 5", obs_inc.size(), pc_i, obs_done); end
  endtask

  task automatic test_nop_and_stray_ack;
    exec(3'd0, 3'd0, 0, 0, 1'b0, 20);
    checks++; if (obs_done !== 1) begin
      errors++; $display("FAIL nop_done: got cycle %0d required 1", obs_done); end
    exec(3'd7, 3'd0, 0, 0, 1'b0, 20);
    checks++; if (obs_done !== 1 || obs_inc.size() !== 0 || obs_load.size() !== 0) begin
      errors++; $display("FAIL cmd7_nop: done %0d incs %0d loads %0d required 1 0 0", obs_done, obs_inc.size(), obs_load.size()); end
    mem_ack_i = 1'b1; mem_data_i = 8'hFF;
    repeat (3) @(negedge clk50M_i);
    mem_ack_i = 1'b0;
    checks++; if ({opcode_o, operand_o, pc_inc_o} !== {m_opcode, m_operand, 1'b0}) begin
      errors++; $display("FAIL stray_ack: got %h required %h", {opcode_o, operand_o, pc_inc_o}, {m_opcode, m_operand, 1'b0}); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      logic [2:0]  c, v;
      logic [15:0] pc0, exp_load, exp_pc;
      logic [7:0]  b0, b1;
      int d0, d1, n, t, first_inc, last_inc, exp_done;
      c = 3'($urandom_range(0, 7)); v = 3'($urandom_range(0, 7));
      d0 = $urandom_range(0, 3); d1 = $urandom_range(0, 3);
      pc0 = 16'($urandom);
      if (it % 8 == 0) pc0 = 16'hFFFF;
      pc_i = pc0;
      n = (c == 3'd1 || c == 3'd2) ? 1 : (c == 3'd3) ? 2 : 0;
      b0 = mem_byte(pc0); b1 = mem_byte(pc0 + 16'd1);
      t = 1; first_inc = -1; last_inc = -1;
      for (int i = 0; i < n; i++) begin
        last_inc = t + ((i == 0) ? d0 : d1) + 1;
        if (i == 0) first_inc = last_inc;
        t = last_inc + 2;
      end
      exp_done = (n > 0) ? last_inc + 2 : (c == 3'd4 || c == 3'd5) ? 3 : 1;
      exp_load = (c == 3'd4) ? m_operand : 16'(v) * 16'd8;
      exp_pc = (n > 0) ? pc0 + 16'(n) : (c == 3'd4 || c == 3'd5) ? exp_load : pc0;
      exec(c, v, d0, d1, 1'($urandom_range(0, 1)), 60);
      if (c == 3'd1) m_opcode = b0;
      if (c == 3'd2) m_operand = {8'h00, b0};
      if (c == 3'd3) m_operand = {b1, b0};
      checks++; if (obs_done !== exp_done || obs_done_cnt !== 1) begin
        errors++; $display("FAIL rand%0d_done: cmd %0d got cycle %0d required %0d", it, c, obs_done, exp_done); end
      checks++; if (obs_inc.size() !== n || (n > 0 && (obs_inc[0] !== first_inc || obs_inc[n-1] !== last_inc))) begin
        errors++; $display("FAIL rand%0d_inc: cmd %0d got %0d pulses required %0d at %0d..%0d", it, c, obs_inc.size(), n, first_inc, last_inc); end
      checks++; if ({opcode_o, operand_o, pc_i} !== {m_opcode, m_operand, exp_pc}) begin
        errors++; $display("FAIL rand%0d_regs: cmd %0d got %h required %h", it, c, {opcode_o, operand_o, pc_i}, {m_opcode, m_operand, exp_pc}); end
      if (c == 3'd4 || c == 3'd5) begin
        checks++; if (obs_load.size() !== 1 || obs_load_addr !== exp_load) begin
          errors++; $display("FAIL rand%0d_load: got %0d loads addr %h required 1 addr %h", it, obs_load.size(), obs_load_addr, exp_load); end
      end
      if (n > 0) begin
        checks++; if (obs_rd.size() !== n || obs_rd[0] !== pc0) begin
          errors++; $display("FAIL rand%0d_rdaddr: got %0d reads first %h required %0d at %h", it, obs_rd.size(), obs_rd.size() > 0 ? obs_rd[0] : 16'hDEAD, n, pc0); end
      end
      checks++; if (obs_ready_after !== 1'b1 || obs_pulse_after !== 1'b0) begin
        errors++; $display("FAIL rand%0d_after: ready %b pulse %b required 1 0", it, obs_ready_after, obs_pulse_after); end
    end
  endtask

  task automatic test_timeout;
    pc_i = 16'h4000;
`ifdef PCSEQ_TIMEOUT_EN
    exec(3'd1, 3'd0, 1000, 0, 1'b0, 40);
    checks++; if (obs_err !== 16 || obs_req_cnt !== 15) begin
      errors++; $display("FAIL timeout_err: err cycle %0d req cycles %0d required 16 15", obs_err, obs_req_cnt); end
    checks++; if (obs_done !== -1 || obs_inc.size() !== 0 || opcode_o !== m_opcode) begin
      errors++; $display("FAIL timeout_side: done %0d incs %0d opcode %h required -1 0 %h", obs_done, obs_inc.size(), opcode_o, m_opcode); end
    checks++; if (obs_ready_after !== 1'b1 || pc_i !== 16'h4000) begin
      errors++; $display("FAIL timeout_idle: ready %b pc %h required 1 4000", obs_ready_after, pc_i); end
`else
    exec(3'd1, 3'd0, 1000, 0, 1'b0, 100);
    checks++; if (mem_req_o !== 1'b1 || obs_req_cnt !== 100) begin
      errors++; $display("FAIL noto_waiting: req %b cycles %0d required 1 100", mem_req_o, obs_req_cnt); end
    checks++; if (obs_err !== -1 || obs_done !== -1 || err_o !== 1'b0) begin
      errors++; $display("FAIL noto_err: err cycle %0d done %0d required none", obs_err, obs_done); end
    rst_i = 1'b1;
    @(negedge clk50M_i); rst_i = 1'b0;
    @(negedge clk50M_i);
    m_opcode = 8'h00; m_operand = 16'h0000;
    checks++; if ({cmd_ready_o, mem_req_o} !== 2'b10) begin
      errors++; $display("FAIL noto_recover: got %b required 10", {cmd_ready_o, mem_req_o}); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_i = 3'd0; vec_i = 3'd0;
    pc_i = 16'h0000; mem_ack_i = 1'b0; mem_data_i = 8'h00;
    m_opcode = 8'h00; m_operand = 16'h0000;
    mem_ovr[16'h0100] = 8'hC3;
    mem_ovr[16'h0200] = 8'h34;
    mem_ovr[16'h0201] = 8'h12;
    mem_ovr[16'hFFFF] = 8'hAA;
    test_reset;
    test_fetch_op_late_ack;
    test_reset_mid_read;
    test_imm16_then_jump;
    test_rst_vec_hold;
    test_imm8_wrap;
    test_nop_and_stray_ack;
    test_random;
    test_timeout;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
